// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by instruction_fetch_stage and fetch_skid_buffer.
package instruction_fetch_stage_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] PC_STEP    = 32'd4;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, pc} holder that catches a returned word while
// the downstream register is stalled.
module fetch_skid_buffer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        unload,
   input  logic        clear,
   input  logic [31:0] data_in,
   input  logic [31:0] pc_in,
   output logic [31:0] data,
   output logic [31:0] pc,
   output logic        full
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
         pc   <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
         data <= data_in;
         pc   <= pc_in;
      end else if (unload) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage feeding IF/ID: owns the PC, runs the IMem req/ready handshake,
// inserts bubbles on wait states and redirects. Option: IFETCH_ALIGN_CHECK_EN.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] Redirect_PC,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Ready,
   input  logic [31:0] IMem_Data,
   output logic [31:0] Instruction_out,
   output logic [31:0] PC_out,
   output logic        Fetch_Valid,
   output logic        Misalign_Err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic         valid_q, valid_d;
   logic         req_q;
   logic         buf_load, buf_unload, buf_clear, buf_full;
   logic [31:0]  buf_data, buf_pc;
   logic [31:0]  next_addr, target;

   assign next_addr = req_addr_q + PC_STEP;
   assign target    = word_align(Redirect_PC);

   fetch_skid_buffer u_skid (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .load    (buf_load),
      .unload  (buf_unload),
      .clear   (buf_clear),
      .data_in (IMem_Data),
      .pc_in   (next_addr),
      .data    (buf_data),
      .pc      (buf_pc),
      .full    (buf_full)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      valid_d    = valid_q;
      buf_load   = 1'b0;
      buf_unload = 1'b0;
      buf_clear  = 1'b0;

      if (Redirect) begin
         instr_d   = NOP_INSTR;
         valid_d   = 1'b0;
         buf_clear = 1'b1;
         pc_d      = target;
         // An unanswered request must still drain; its address stays on the bus.
         if (req_q && !IMem_Ready) begin
            state_d = DISCARD;
         end else begin
            req_addr_d = target;
            state_d    = FETCH;
         end
      end else begin
         unique case (state_q)
            FETCH: begin
               // req_q is low only in the first cycle after reset.
               if (req_q) begin
                  if (IMem_Ready) begin
                     pc_d       = next_addr;
                     req_addr_d = next_addr;
                     if (Stall) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                     end else begin
                        instr_d  = IMem_Data;
                        pc_out_d = next_addr;
                        valid_d  = 1'b1;
                     end
                  end else if (!Stall) begin
                     instr_d = NOP_INSTR;
                     valid_d = 1'b0;
                  end
               end
            end
            HOLD: begin
               if (!Stall) begin
                  instr_d    = buf_data;
                  pc_out_d   = buf_pc;
                  valid_d    = buf_full;
                  buf_unload = 1'b1;
                  state_d    = FETCH;
               end
            end
            DISCARD: begin
               if (IMem_Ready) begin
                  req_addr_d = pc_q;
                  state_d    = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_out_q   <= '0;
         valid_q    <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         valid_q    <= valid_d;
         req_q      <= (state_d != HOLD);
      end
   end

`ifdef IFETCH_ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         misalign_q <= 1'b0;
      end else if (Redirect && (Redirect_PC != target)) begin
         misalign_q <= 1'b1;
      end
   end

   assign Misalign_Err = misalign_q;
`else
   assign Misalign_Err = 1'b0;
`endif

   assign IMem_Req        = req_q;
   assign IMem_Addr       = req_addr_q;
   assign Instruction_out = instr_q;
   assign PC_out          = pc_out_q;
   assign Fetch_Valid     = valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage; memory returns addr>>2.
// Build with IFETCH_ALIGN_CHECK_EN defined to exercise the misalign flag.
module tb_instruction_fetch_stage;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Stall = 1'b0;
   logic        Redirect = 1'b0;
   logic [31:0] Redirect_PC = '0;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Ready = 1'b1;
   logic [31:0] IMem_Data;
   logic [31:0] Instruction_out;
   logic [31:0] PC_out;
   logic        Fetch_Valid;
   logic        Misalign_Err;

`ifdef IFETCH_ALIGN_CHECK_EN
   localparam logic MIS_EN = 1'b1;
`else
   localparam logic MIS_EN = 1'b0;
`endif

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        mis;
   } obs_t;

   typedef struct packed {
      logic        ready;
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
   } stim_t;

   stim_t stim_q[$];
   obs_t  exp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .Clk             (Clk),
      .Rst_n           (Rst_n),
      .Stall           (Stall),
      .Redirect        (Redirect),
      .Redirect_PC     (Redirect_PC),
      .IMem_Req        (IMem_Req),
      .IMem_Addr       (IMem_Addr),
      .IMem_Ready      (IMem_Ready),
      .IMem_Data       (IMem_Data),
      .Instruction_out (Instruction_out),
      .PC_out          (PC_out),
      .Fetch_Valid     (Fetch_Valid),
      .Misalign_Err    (Misalign_Err)
   );

   always #5 Clk = ~Clk;
   assign IMem_Data = IMem_Addr >> 2;

   function automatic obs_t observe();
      return '{IMem_Req, IMem_Addr, Instruction_out, PC_out, Fetch_Valid, Misalign_Err};
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("req=%b addr=%h instr=%h pc=%h valid=%b mis=%b",
                       o.req, o.addr, o.instr, o.pc, o.valid, o.mis);
   endfunction

   function automatic void push(logic ready, logic stall, logic redir, logic [31:0] rpc,
                                logic req, logic [31:0] addr, logic [31:0] instr,
                                logic [31:0] pc, logic valid, logic mis);
      stim_q.push_back('{ready, stall, redir, rpc});
      exp_q.push_back('{req, addr, instr, pc, valid, mis});
   endfunction

   task automatic do_reset();
      stim_q.delete();
      exp_q.delete();
      IMem_Ready = 1'b1;
      Stall = 1'b0;
      Redirect = 1'b0;
      Redirect_PC = '0;
      Rst_n = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      stim_t s;
      obs_t  e, got;
      int    step = 0;
      do_reset();
      push(1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0);
      push(1, 0, 0, 0, 1, 32'h4, 32'h0, 32'h4, 1, 0);
      push(1, 0, 0, 0, 1, 32'h8, 32'h1, 32'h8, 1, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_release step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
      // Asynchronous assertion between edges, mid-request.
      #3 Rst_n = 1'b0;
      #1 got = observe(); n_checks++;
      if (got !== obs_t'(0)) begin
         n_fail++;
         $display("FAIL reset_async: got %s, expected all zero", fmt(got));
      end
      @(posedge Clk); #1;
      got = observe(); n_checks++;
      if (got !== obs_t'(0)) begin
         n_fail++;
         $display("FAIL reset_held: got %s, expected all zero", fmt(got));
      end
      Rst_n = 1'b1;
      push(1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0);
      push(1, 0, 0, 0, 1, 32'h4, 32'h0, 32'h4, 1, 0);
      step = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_rerelease step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_zero_wait();
      stim_t s;
      obs_t  e, got;
      int    step = 0;
      do_reset();
      push(1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0);
      for (int k = 2; k <= 9; k++)
         push(1, 0, 0, 0, 1, 32'(4 * (k - 1)), 32'(k - 2), 32'(4 * (k - 1)), 1, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL zero_wait step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_wait_states();
      stim_t s;
      obs_t  e, got;
      int    step = 0;
      do_reset();
      push(1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0);
      push(1, 0, 0, 0, 1, 32'h4, 32'h0, 32'h4, 1, 0);
      push(1, 0, 0, 0, 1, 32'h8, 32'h1, 32'h8, 1, 0);
      for (int k = 0; k < 3; k++)
         push(0, 0, 0, 0, 1, 32'h8, 32'h0, 32'h8, 0, 0);
      push(1, 0, 0, 0, 1, 32'hC,  32'h2, 32'hC,  1, 0);
      push(1, 0, 0, 0, 1, 32'h10, 32'h3, 32'h10, 1, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL wait_states step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_stall();
      stim_t s;
      obs_t  e, got;
      int    step = 0;
      do_reset();
      push(1, 0, 0, 0, 1, 32'h0,  32'h0, 32'h0,  0, 0);
      push(1, 0, 0, 0, 1, 32'h4,  32'h0, 32'h4,  1, 0);
      push(1, 1, 0, 0, 0, 32'h8,  32'h0, 32'h4,  1, 0);
      push(1, 1, 0, 0, 0, 32'h8,  32'h0, 32'h4,  1, 0);
      push(1, 0, 0, 0, 1, 32'h8,  32'h1, 32'h8,  1, 0);
      push(1, 0, 0, 0, 1, 32'hC,  32'h2, 32'hC,  1, 0);
      push(0, 1, 0, 0, 1, 32'hC,  32'h2, 32'hC,  1, 0);
      push(1, 0, 0, 0, 1, 32'h10, 32'h3, 32'h10, 1, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL stall step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_redirect_discard();
      stim_t s;
      obs_t  e, got;
      int    step = 0;
      do_reset();
      push(1, 0, 0, 0,          1, 32'h0,   32'h0,  32'h0,   0, 0);
      push(1, 0, 0, 0,          1, 32'h4,   32'h0,  32'h4,   1, 0);
      push(1, 0, 0, 0,          1, 32'h8,   32'h1,  32'h8,   1, 0);
      push(0, 0, 1, 32'h100,    1, 32'h8,   32'h0,  32'h8,   0, 0);
      push(0, 0, 0, 0,          1, 32'h8,   32'h0,  32'h8,   0, 0);
      push(1, 0, 0, 0,          1, 32'h100, 32'h0,  32'h8,   0, 0);
      push(1, 0, 0, 0,          1, 32'h104, 32'h40, 32'h104, 1, 0);
      push(1, 0, 0, 0,          1, 32'h108, 32'h41, 32'h108, 1, 0);
      push(0, 0, 1, 32'h200,    1, 32'h108, 32'h0,  32'h108, 0, 0);
      push(0, 0, 1, 32'h300,    1, 32'h108, 32'h0,  32'h108, 0, 0);
      push(1, 0, 0, 0,          1, 32'h300, 32'h0,  32'h108, 0, 0);
      push(1, 0, 0, 0,          1, 32'h304, 32'hC0, 32'h304, 1, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL redirect_discard step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_redirect_stall();
      stim_t s;
      obs_t  e, got;
      int    step = 0;
      do_reset();
      push(1, 0, 0, 0,       1, 32'h0,  32'h0,  32'h0,  0, 0);
      push(1, 0, 0, 0,       1, 32'h4,  32'h0,  32'h4,  1, 0);
      push(1, 1, 1, 32'h40,  1, 32'h40, 32'h0,  32'h4,  0, 0);
      push(1, 0, 0, 0,       1, 32'h44, 32'h10, 32'h44, 1, 0);
      push(1, 1, 0, 0,       0, 32'h48, 32'h10, 32'h44, 1, 0);
      push(1, 1, 1, 32'h80,  1, 32'h80, 32'h0,  32'h44, 0, 0);
      push(1, 0, 0, 0,       1, 32'h84, 32'h20, 32'h84, 1, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL redirect_stall step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_wrap_align();
      stim_t s;
      obs_t  e, got;
      int    step = 0;
      do_reset();
      push(1, 0, 0, 0,            1, 32'h0,         32'h0,         32'h0,   0, 0);
      push(1, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0,         32'h0,   0, 0);
      push(1, 0, 0, 0,            1, 32'h0,         32'h3FFF_FFFF, 32'h0,   1, 0);
      push(1, 0, 0, 0,            1, 32'h4,         32'h0,         32'h4,   1, 0);
      push(1, 0, 1, 32'h102,      1, 32'h100,       32'h0,         32'h4,   0, MIS_EN);
      push(1, 0, 0, 0,            1, 32'h104,       32'h40,        32'h104, 1, MIS_EN);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         IMem_Ready = s.ready; Stall = s.stall; Redirect = s.redirect; Redirect_PC = s.rpc;
         @(posedge Clk); #1;
         got = observe(); n_checks++; step++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL wrap_align step %0d: got %s, expected %s", step, fmt(got), fmt(e));
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_redirect_discard();
      test_redirect_stall();
      test_wrap_align();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage directly upstream of the IF/ID pipeline register. Owns the program counter, issues one instruction-memory request per instruction over a request/ready handshake, and presents {Instruction_out, PC_out} for IF/ID to capture. Honours the same Stall/flush controls as IF/ID, and inserts NOP bubbles (32'h0) when memory is slow or a redirect occurs.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- Clk  in  1  clock, all state updates on posedge
- Rst_n  in  1  asynchronous, active-low reset
- Stall  in  1  same signal driving IF/ID Stall; presented outputs were not consumed
- Redirect  in  1  taken branch/jump; same cycle as IF/ID flush
- Redirect_PC  in  32  redirect target
- IMem_Req  out  1  request valid
- IMem_Addr  out  32  request address, word aligned
- IMem_Ready  in  1  response valid; completes the handshake when IMem_Req=1
- IMem_Data  in  32  instruction word, valid with IMem_Ready
- Instruction_out  out  32  to IF/ID Instruction_in; 32'h0 when bubble
- PC_out  out  32  to IF/ID PC_in; fetch address + 4
- Fetch_Valid  out  1  1 = Instruction_out is a real instruction
- Misalign_Err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: PC (next address to fetch), Req_Addr (outstanding request address), output registers, 1-entry skid buffer, state.
- Reset (async, Rst_n=0): state FETCH, PC=Req_Addr=RESET_PC, IMem_Req=0, Instruction_out=0, PC_out=0, Fetch_Valid=0, buffer empty, Misalign_Err=0.
- Handshake: once IMem_Req=1, IMem_Req and IMem_Addr stay stable until a cycle with IMem_Ready=1. IMem_Ready is ignored when IMem_Req=0.
- States:
  - FETCH: IMem_Req=1, IMem_Addr=Req_Addr.
    - Ready=1, Stall=0: outputs load {IMem_Data, Req_Addr+4, 1}, and PC and Req_Addr advance by 4.
    - Ready=1, Stall=1: data goes into the skid buffer, PC and Req_Addr advance, outputs hold, go to HOLD.
    - Ready=0, Stall=0: outputs load bubble {0, PC_out unchanged, 0}.
    - Ready=0, Stall=1: outputs hold.
  - HOLD: IMem_Req=0. While Stall=1, hold. First edge with Stall=0: outputs load the buffer, buffer empties, go to FETCH.
  - DISCARD: IMem_Req=1 with the old Req_Addr. On Ready=1 the data is dropped, Req_Addr<=PC, go to FETCH. Outputs stay bubble.
- Redirect has priority over Stall and over all states. On an edge with Redirect=1:
  - Outputs become bubble, buffer clears, PC<=Redirect_PC.
  - If a request is outstanding with Ready=0, go to DISCARD.
  - Otherwise (Ready=1 that cycle, HOLD, or FETCH) Req_Addr<=Redirect_PC and go to FETCH. Data returned in that cycle is dropped.
- A Redirect while in DISCARD updates PC only; the state stays DISCARD.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0. PC_out wraps the same way.

## Timing
- Zero-wait memory (Ready tied 1): one instruction per cycle. Instruction for address A appears on the outputs at the edge after A is presented.
- First IMem_Req=1 is the first cycle after Rst_n deasserts.
- N wait cycles produce N bubbles.
- Redirect latency: the target address appears on IMem_Addr in the cycle after the Redirect edge, or in the cycle after the drained Ready when in DISCARD.
- Reset asserted mid-request drops the transaction. The memory side must also be reset.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined: a Redirect_PC with non-zero bits [1:0] sets Misalign_Err (sticky until reset). The fetch proceeds with bits [1:0] forced to 00.
- Undefined: bits [1:0] are silently forced to 00, and Misalign_Err is tied 0.

## Structure
- Shared package: state encoding (FETCH, HOLD, DISCARD), NOP_INSTR=32'h0, PC_STEP=4.
- One sub-module, fetch_skid_buffer: a 1-entry {data, pc} holder with load, unload and clear.

## Test plan
- Reset release, RESET_PC=0, Ready tied 1, memory returning addr>>2 -> IMem_Addr 0,4,8,… and Instruction_out 0,1,2 with PC_out 4,8,12, one per cycle.
- Ready low for 3 cycles on address 8 -> 3 bubbles (Fetch_Valid=0, Instruction_out=0), IMem_Addr held at 8, then instruction 2 with PC_out=12.
- Stall high 2 cycles while Ready=1 on address 4 -> outputs held, IMem_Req=0 during HOLD, and instruction 1 is presented on the first edge after Stall drops.
- Redirect to 32'h100 while address 8 is outstanding with Ready low -> DISCARD, data for 8 dropped, next IMem_Addr=32'h100, first valid PC_out=32'h104.
- Redirect and Stall together -> bubble output and fetch from the target, i.e. Redirect wins.
- Redirect to 32'hFFFF_FFFC -> fetches FFFF_FFFC then 0, PC_out=0 for the first. With IFETCH_ALIGN_CHECK_EN, Redirect to 32'h102 -> Misalign_Err=1 and IMem_Addr=32'h100.
